// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding
// and the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full-adder cell; the only arithmetic in the serial datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic COUT
);

  assign SUM  = A ^ B ^ CIN;
  assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts A/B/CIN, adds LSB first through a
// single full-adder cell, and publishes SUM/COUT with a one-cycle DONE.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START_VALID,
  output logic             START_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             DONE,
  output logic             BUSY
);

  // One extra counter bit so the post-increment value WIDTH never wraps.
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             last_s;

  full_adder u_cell (
    .A    (a_sh_r[0]),
    .B    (b_sh_r[0]),
    .CIN  (carry_r),
    .SUM  (fa_sum_s),
    .COUT (fa_cout_s)
  );

  assign last_s = (cnt_r == LAST_CNT);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (START_VALID) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Result word with the current cell sum written into bit [cnt_r]
  always_comb begin
    res_nxt_s = res_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_r == CW'(i)) begin
        res_nxt_s[i] = fa_sum_s;
      end else begin
        res_nxt_s[i] = res_r[i];
      end
    end
  end

  // Operand shifters, carry, counter, partial result and published result
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (START_VALID) begin
            a_sh_r  <= A;
            b_sh_r  <= B;
            carry_r <= CIN;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          res_r   <= res_nxt_s;
          carry_r <= fa_cout_s;
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          cnt_r   <= cnt_r + CW'(1);
          // SUM/COUT only change here, so partial results never leak out.
          if (last_s) begin
            sum_r  <= res_nxt_s;
            cout_r <= fa_cout_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign START_READY = (state_r == IDLE);
  assign BUSY        = (state_r == RUN) || (state_r == FIN);
  assign DONE        = (state_r == FIN);
  assign SUM         = sum_r;
  assign COUT        = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;
  logic         busy;

  logic         sv1;
  logic         ready1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         cin1;
  logic [0:0]   sum1;
  logic         cout1;
  logic         done1;
  logic         busy1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t       vecs[10];
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .START_VALID(start_valid), .START_READY(start_ready),
    .A(a), .B(b), .CIN(cin), .SUM(sum), .COUT(cout), .DONE(done), .BUSY(busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst), .START_VALID(sv1), .START_READY(ready1),
    .A(a1), .B(b1), .CIN(cin1), .SUM(sum1), .COUT(cout1), .DONE(done1), .BUSY(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every DONE pops the oldest expected {sum,cout}
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: DONE=1 with no operation outstanding at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sum", {24'h0, sum}, {24'h0, mon_e[8:1]});
          check("cout", {31'h0, cout}, {31'h0, mon_e[0]});
        end
        check("done_ready_excl", {31'h0, start_ready}, 32'h0);
      end
    end
  end

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec, input bit hold);
    int k;
    logic [8:0] prev;
    k = 0;
    while (!start_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_accept", {31'h0, start_ready}, 32'h1);
    prev        = {sum, cout};
    start_valid = 1'b1;
    a           = va;
    b           = vb;
    cin         = vc;
    @(posedge clk);
    exp_q.push_back({es, ec});
    @(negedge clk);
    if (hold) begin
      a   = 8'hFF;
      b   = 8'hFF;
      cin = 1'b1;
    end else begin
      start_valid = 1'b0;
      a           = ~va;
      b           = ~vb;
      cin         = ~vc;
    end
    k = 0;
    while (!done && k < W + 5) begin
      check("no_partial", {23'h0, sum, cout}, {23'h0, prev});
      check("ready_low_run", {31'h0, start_ready}, 32'h0);
      check("busy_run", {31'h0, busy}, 32'h1);
      @(negedge clk);
      k++;
    end
    check("done_latency", k, W);
    check("busy_fin", {31'h0, busy}, 32'h1);
    start_valid = 1'b0;
    @(negedge clk);
    check("ready_after_fin", {31'h0, start_ready}, 32'h1);
    check("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  initial begin
    logic [1:0] s2;
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
    vecs[8] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1; start_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    sv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_sum", {24'h0, sum}, 32'h0);
    check("reset_cout", {31'h0, cout}, 32'h0);
    check("reset_ready", {31'h0, start_ready}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_ready_w1", {31'h0, ready1}, 32'h1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, 1'b0);
    end

    // START_VALID held with FF/FF during RUN/FIN must not alter the result
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);

    // Reset at the 3rd RUN edge discards the operation (and beats START_VALID)
    @(negedge clk);
    start_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start_valid = 1'b0;
    check("rst_run_ready", {31'h0, start_ready}, 32'h1);
    check("rst_run_busy", {31'h0, busy}, 32'h0);
    check("rst_run_sum", {24'h0, sum}, 32'h0);
    check("rst_run_cout", {31'h0, cout}, 32'h0);
    repeat (W + 3) @(negedge clk);
    check("rst_run_idle_after", {31'h0, start_ready}, 32'h1);

    // WIDTH=1: all eight operand combinations
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sv1 = 1'b1; a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      s2 = 2'(a1) + 2'(b1) + 2'(cin1);
      @(posedge clk);
      @(negedge clk);
      sv1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      check("w1_run_busy", {31'h0, busy1}, 32'h1);
      check("w1_run_no_done", {31'h0, done1}, 32'h0);
      @(negedge clk);
      check("w1_done", {31'h0, done1}, 32'h1);
      check("w1_sum", {31'h0, sum1}, {31'h0, s2[0]});
      check("w1_cout", {31'h0, cout1}, {31'h0, s2[1]});
      check("w1_ready_excl", {31'h0, ready1}, 32'h0);
      @(negedge clk);
      check("w1_ready_after", {31'h0, ready1}, 32'h1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
